// File: rtl/bmf_pkg.sv
// Shared types and helpers for the BMF decompressor stream.
//   mode_e      : product semiring select (OR or GF(2)/XOR)
//   default_bit : which factor bit row j of the default H matrix selects
//   popcount    : number of ones in a 64-bit vector
//   sat_add     : saturating add with an explicit ceiling
package bmf_pkg;

    typedef enum logic {
        MODE_OR  = 1'b0,
        MODE_XOR = 1'b1
    } mode_e;

    // Rows 0..M-K all pick k0; the remaining K-1 rows pick k1..k(K-1).
    function automatic int default_bit(input int j, input int k, input int m);
        if (j <= m - k) begin
            return 0;
        end
        return j - (m - k);
    endfunction

    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] cnt;
        cnt = '0;
        for (int i = 0; i < 64; i++) begin
            cnt = cnt + 7'(v[i]);
        end
        return cnt;
    endfunction

    // One extra carry bit catches wrap-around when the ceiling is all ones.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input logic [63:0] max);
        logic [64:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max}) begin
            return max;
        end
        return sum[63:0];
    endfunction

endpackage

// File: rtl/bmf_h_row.sv
// One output bit of the decompressor: dot product of an H row with the
// factor vector under the selected semiring.
//   i_row  : H row, bit i = H[j][i]
//   i_k    : factor vector
//   i_mode : MODE_OR -> OR of ANDs, MODE_XOR -> parity of ANDs
//   o_bit  : resulting output bit
module bmf_h_row
    import bmf_pkg::*;
#(
    parameter int K = 5
) (
    input  logic [K-1:0] i_row,
    input  logic [K-1:0] i_k,
    input  mode_e        i_mode,
    output logic         o_bit
);

    logic [K-1:0] w_and;

    assign w_and = i_row & i_k;
    assign o_bit = (i_mode == MODE_XOR) ? ^w_and : |w_and;

endmodule

// File: rtl/bmf_decomp_stream.sv
// Streaming BMF decompressor: expands K-bit factor vectors to M outputs
// through a run-time programmable K x M Boolean H matrix, two-stage
// valid/ready pipeline.
// Optional feature macro: BMF_ERR_STATS_EN (Hamming error / vector counters
// against an exact reference; when undefined the counters read 0 and
// in_exact / clr_stats are ignored).
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   cfg_we, cfg_addr, cfg_wdata      write H row cfg_addr (bit i = H[j][i])
//   cfg_mode_we, cfg_mode            write mode (0 = OR, 1 = XOR)
//   in_valid, in_ready, in_k, in_exact   input stream
//   out_valid, out_ready, out_data   output stream
//   clr_stats, err_count, vec_count  statistics
// Handshake: a beat transfers on a rising edge where valid & ready are both
// high; a producer holding valid keeps its data stable until the transfer,
// and out_data is held while out_valid & !out_ready. in_ready depends only
// on pipeline state and out_ready, never on in_valid.
module bmf_decomp_stream
    import bmf_pkg::*;
#(
    parameter int K     = 5,
    parameter int M     = 8,
    parameter int CNT_W = 32,
    parameter int AW    = $clog2(M)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [K-1:0]     cfg_wdata,
    input  logic             cfg_mode_we,
    input  logic             cfg_mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [K-1:0]     in_k,
    input  logic [M-1:0]     in_exact,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M-1:0]     out_data,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] vec_count
);

    logic [K-1:0] r_h [M];
    mode_e        r_mode;
    logic         r_s1_valid;
    logic [K-1:0] r_s1_k;
    logic         r_out_valid;
    logic [M-1:0] r_out_data;
    logic [M-1:0] w_prod;
    logic         w_s1_adv;
    logic         w_s2_adv;

    assign w_s2_adv  = !r_out_valid | out_ready;
    assign w_s1_adv  = !r_s1_valid | w_s2_adv;
    assign in_ready  = w_s1_adv;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    // Config registers. The product reads r_h/r_mode directly, so a write
    // lands one edge later and affects every later s1->s2 move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < M; j++) begin
                r_h[j] <= K'(1) << default_bit(j, K, M);
            end
            r_mode <= MODE_OR;
        end else begin
            if (cfg_we && (32'(cfg_addr) < M)) begin
                r_h[cfg_addr] <= cfg_wdata;
            end
            if (cfg_mode_we) begin
                r_mode <= mode_e'(cfg_mode);
            end
        end
    end

    for (genvar j = 0; j < M; j++) begin : g_row
        bmf_h_row #(.K(K)) u_row (
            .i_row  (r_h[j]),
            .i_k    (r_s1_k),
            .i_mode (r_mode),
            .o_bit  (w_prod[j])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_k      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_k <= in_k;
                end
            end
            if (w_s2_adv) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_data <= w_prod;
                end
            end
        end
    end

`ifdef BMF_ERR_STATS_EN
    // Shift by CNT_W = 64 yields 0, so the ceiling becomes all ones.
    localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    logic [M-1:0]     r_s1_exact;
    logic [M-1:0]     r_s2_exact;
    logic [CNT_W-1:0] r_err;
    logic [CNT_W-1:0] r_vec;
    logic             w_xfer;
    logic [6:0]       w_pop;

    assign w_xfer    = r_out_valid & out_ready;
    assign w_pop     = popcount(64'(r_out_data ^ r_s2_exact));
    assign err_count = r_err;
    assign vec_count = r_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_exact <= '0;
            r_s2_exact <= '0;
            r_err      <= '0;
            r_vec      <= '0;
        end else begin
            if (w_s1_adv && in_valid) begin
                r_s1_exact <= in_exact;
            end
            if (w_s2_adv && r_s1_valid) begin
                r_s2_exact <= r_s1_exact;
            end
            // Clear takes priority over a coincident transfer.
            if (clr_stats) begin
                r_err <= '0;
                r_vec <= '0;
            end else if (w_xfer) begin
                r_err <= CNT_W'(sat_add(64'(r_err), 64'(w_pop), CNT_MAX));
                r_vec <= CNT_W'(sat_add(64'(r_vec), 64'd1, CNT_MAX));
            end
        end
    end
`else
    logic w_unused_stats;

    assign w_unused_stats = ^{in_exact, clr_stats};
    assign err_count      = '0;
    assign vec_count      = '0;
`endif

endmodule
